grf_thresh_monitor: RTL and testbench

GRF_THRESH_MONITOR -- requirements
Module: grf_thresh_monitor

---
 rtl/grf_thresh_monitor.sv | 138 +++++++++++++
 tb/tb_grf_thresh_monitor.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_thresh_monitor.sv
// grf_thresh_monitor: debounced, hysteretic threshold detector on a sample stream.
// res rises after HOLD consecutive high samples and falls after HOLD consecutive
// low samples. Rising transitions are counted (saturating), and a sticky flag
// records any high sample since reset or clr.
module grf_thresh_monitor #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] THRESH_HI = WIDTH'(16'h0020),
    parameter logic [WIDTH-1:0] THRESH_LO = WIDTH'(16'h0018),
    parameter int unsigned      HOLD      = 3,
    parameter int unsigned      CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] grf,
    input  logic             clr,
    output logic             res,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             cnt_sat,
    output logic             sticky_hit
);

    // Run counter must hold values up to HOLD.
    localparam int unsigned      RUN_W   = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam logic [RUN_W-1:0] HOLD_V  = RUN_W'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        StLow  = 2'd0,
        StRise = 2'd1,
        StHigh = 2'd2,
        StFall = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] run_inc;
    logic             run_last;
    logic             is_high;
    logic             is_low;
    logic             hit;
    logic             rise_event;
    logic [CNT_W-1:0] rise_cnt_q;
    logic             sticky_q;

    // Sample classification; THRESH_LO <= THRESH_HI keeps high and low disjoint.
    always_comb begin
        is_high  = (grf >= THRESH_HI);
        is_low   = (grf < THRESH_LO);
        hit      = in_valid & is_high;
        run_inc  = run_q + RUN_W'(1);
        // run_q is zero in the stable states, so run_inc == 1 there and HOLD=1
        // flips directly without a separate case.
        run_last = (run_inc == HOLD_V);
    end

    // Next-state and run counter; nothing moves on non-valid cycles.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        rise_event = 1'b0;
        if (in_valid) begin
            case (state_q)
                StLow, StRise: begin
                    if (is_high) begin
                        if (run_last) begin
                            state_d    = StHigh;
                            run_d      = '0;
                            rise_event = 1'b1;
                        end else begin
                            state_d = StRise;
                            run_d   = run_inc;
                        end
                    end else begin
                        state_d = StLow;
                        run_d   = '0;
                    end
                end
                StHigh, StFall: begin
                    if (is_low) begin
                        if (run_last) begin
                            state_d = StLow;
                            run_d   = '0;
                        end else begin
                            state_d = StFall;
                            run_d   = run_inc;
                        end
                    end else begin
                        state_d = StHigh;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = StLow;
                    run_d   = '0;
                end
            endcase
        end
    end

    // FSM state and run counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLow;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Rise counter and sticky flag; a same-cycle event wins over clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_cnt_q <= '0;
            sticky_q   <= 1'b0;
        end else if (clr) begin
            rise_cnt_q <= rise_event ? CNT_W'(1) : '0;
            sticky_q   <= hit;
        end else begin
            if (rise_event && (rise_cnt_q != CNT_MAX)) begin
                rise_cnt_q <= rise_cnt_q + CNT_W'(1);
            end
            if (hit) begin
                sticky_q <= 1'b1;
            end
        end
    end

    // Outputs decoded straight from registers.
    always_comb begin
        res        = (state_q == StHigh) || (state_q == StFall);
        rise_cnt   = rise_cnt_q;
        cnt_sat    = (rise_cnt_q == CNT_MAX);
        sticky_hit = sticky_q;
    end

endmodule

// File: tb/tb_grf_thresh_monitor.sv
// Self-checking bench for grf_thresh_monitor: directed vector table, hand-written
// corner sequences and randomized stimulus against a behavioural model.
module tb_grf_thresh_monitor;

    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] grf = '0;
    logic        clr = 1'b0;
    logic        res;
    logic [7:0]  rise_cnt;
    logic        cnt_sat;
    logic        sticky_hit;

    // HOLD=1 instance
    logic        h_valid = 1'b0;
    logic [15:0] h_grf = '0;
    logic        h_res;
    logic [7:0]  h_cnt;
    logic        h_sat;
    logic        h_sticky;

    int checks = 0;
    int errors = 0;

    // Behavioural model: current result, length of current qualifying run.
    bit m_res;
    int m_run;
    int m_cnt;
    bit m_sticky;

    typedef struct {
        logic        v;
        logic [15:0] g;
        logic        c;
        logic        r;
        logic [7:0]  n;
        logic        s;
    } vec_t;

    vec_t tbl[29];

    grf_thresh_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .grf        (grf),
        .clr        (clr),
        .res        (res),
        .rise_cnt   (rise_cnt),
        .cnt_sat    (cnt_sat),
        .sticky_hit (sticky_hit)
    );

    grf_thresh_monitor #(.HOLD(1)) dut_h1 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (h_valid),
        .grf        (h_grf),
        .clr        (1'b0),
        .res        (h_res),
        .rise_cnt   (h_cnt),
        .cnt_sat    (h_sat),
        .sticky_hit (h_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_res    = 1'b0;
        m_run    = 0;
        m_cnt    = 0;
        m_sticky = 1'b0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] g, input bit c);
        bit hi, lo, qual, rise;
        hi   = (g >= 16'h0020);
        lo   = (g < 16'h0018);
        rise = 1'b0;
        if (v) begin
            qual = m_res ? lo : hi;
            if (qual) begin
                m_run++;
                if (m_run == HOLD) begin
                    m_res = ~m_res;
                    m_run = 0;
                    rise  = m_res;
                end
            end else begin
                m_run = 0;
            end
        end
        if (c) begin
            m_cnt    = rise ? 1 : 0;
            m_sticky = v && hi;
        end else begin
            if (rise && m_cnt < 255) m_cnt++;
            if (v && hi) m_sticky = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".res"}, 32'(res), 32'(m_res));
        chk({tag, ".rise_cnt"}, 32'(rise_cnt), 32'(m_cnt));
        chk({tag, ".cnt_sat"}, 32'(cnt_sat), 32'(m_cnt == 255));
        chk({tag, ".sticky"}, 32'(sticky_hit), 32'(m_sticky));
    endtask

    // Drive one cycle of inputs, let the edge capture them, settle past the edge.
    task automatic step(input bit v, input logic [15:0] g, input bit c);
        @(negedge clk);
        in_valid = v;
        grf      = g;
        clr      = c;
        @(posedge clk);
        model_step(v, g, c);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [15:0] pick_grf();
        case ($urandom_range(0, 4))
            0:       return 16'h0020 + 16'($urandom_range(0, 4));
            1:       return 16'h0014 + 16'($urandom_range(0, 3));
            2:       return 16'h0018 + 16'($urandom_range(0, 7));
            3:       return 16'($urandom);
            default: return ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    initial begin
        // {valid, grf, clr, exp res, exp rise_cnt, exp sticky}
        tbl[0]  = '{1'b1, 16'h0020, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[1]  = '{1'b1, 16'h0020, 1'b0, 1'b0, 8'd0, 1'b1};
        tbl[2]  = '{1'b1, 16'h0020, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[3]  = '{1'b1, 16'h001C, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[4]  = '{1'b1, 16'h001C, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[5]  = '{1'b1, 16'h001C, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[6]  = '{1'b1, 16'h001C, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[7]  = '{1'b1, 16'h001C, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[8]  = '{1'b1, 16'h0017, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[9]  = '{1'b1, 16'h0017, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[10] = '{1'b1, 16'h001F, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[11] = '{1'b1, 16'h0017, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[12] = '{1'b1, 16'h0017, 1'b0, 1'b1, 8'd1, 1'b1};
        tbl[13] = '{1'b1, 16'h0017, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[14] = '{1'b1, 16'h0030, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[15] = '{1'b1, 16'h0030, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[16] = '{1'b0, 16'h0030, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[17] = '{1'b0, 16'h0030, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[18] = '{1'b1, 16'h001C, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[19] = '{1'b1, 16'h0030, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[20] = '{1'b1, 16'h0030, 1'b0, 1'b0, 8'd1, 1'b1};
        tbl[21] = '{1'b1, 16'h0030, 1'b0, 1'b1, 8'd2, 1'b1};
        tbl[22] = '{1'b1, 16'h0030, 1'b1, 1'b1, 8'd0, 1'b1};
        tbl[23] = '{1'b1, 16'h0010, 1'b1, 1'b1, 8'd0, 1'b0};
        tbl[24] = '{1'b0, 16'h0010, 1'b0, 1'b1, 8'd0, 1'b0};
        tbl[25] = '{1'b1, 16'hFFFF, 1'b0, 1'b1, 8'd0, 1'b1};
        tbl[26] = '{1'b1, 16'h0000, 1'b0, 1'b1, 8'd0, 1'b1};
        tbl[27] = '{1'b1, 16'h0000, 1'b0, 1'b1, 8'd0, 1'b1};
        tbl[28] = '{1'b1, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b1};

        model_reset();
        #1;
        chk("reset.res", 32'(res), 32'd0);
        chk("reset.rise_cnt", 32'(rise_cnt), 32'd0);
        chk("reset.cnt_sat", 32'(cnt_sat), 32'd0);
        chk("reset.sticky", 32'(sticky_hit), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // HOLD=1 build flips on a single qualifying sample.
        @(negedge clk);
        h_valid = 1'b1;
        h_grf   = 16'h0020;
        @(posedge clk);
        #1;
        chk("hold1.rise.res", 32'(h_res), 32'd1);
        chk("hold1.rise.cnt", 32'(h_cnt), 32'd1);
        @(negedge clk);
        h_grf = 16'h0000;
        @(posedge clk);
        #1;
        chk("hold1.fall.res", 32'(h_res), 32'd0);
        @(negedge clk);
        h_valid = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 29; i++) begin
            step(tbl[i].v, tbl[i].g, tbl[i].c);
            chk($sformatf("vec%0d.res", i), 32'(res), 32'(tbl[i].r));
            chk($sformatf("vec%0d.rise_cnt", i), 32'(rise_cnt), 32'(tbl[i].n));
            chk($sformatf("vec%0d.sticky", i), 32'(sticky_hit), 32'(tbl[i].s));
        end

        // Randomized stimulus against the model.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 8, pick_grf(), $urandom_range(0, 19) == 0);
            check_model($sformatf("rand%0d", i));
        end

        // Saturation: 256 rise events, then clr coinciding with the next rise.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 3; k++) step(1'b1, 16'h0040, 1'b0);
            if (i < 255) begin
                for (int k = 0; k < 3; k++) step(1'b1, 16'h0005, 1'b0);
            end
            if (i == 254) chk("sat.cnt_254", 32'(rise_cnt), 32'hFF);
        end
        chk("sat.cnt", 32'(rise_cnt), 32'hFF);
        chk("sat.flag", 32'(cnt_sat), 32'd1);
        check_model("sat");
        for (int k = 0; k < 3; k++) step(1'b1, 16'h0005, 1'b0);
        step(1'b1, 16'h0040, 1'b0);
        step(1'b1, 16'h0040, 1'b0);
        step(1'b1, 16'h0040, 1'b1);
        chk("satclr.cnt", 32'(rise_cnt), 32'd1);
        chk("satclr.flag", 32'(cnt_sat), 32'd0);
        chk("satclr.res", 32'(res), 32'd1);

        // Async reset while in FALL with two low samples captured.
        step(1'b1, 16'h0010, 1'b0);
        step(1'b1, 16'h0010, 1'b0);
        chk("fall2.res", 32'(res), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async.res", 32'(res), 32'd0);
        chk("async.rise_cnt", 32'(rise_cnt), 32'd0);
        chk("async.sticky", 32'(sticky_hit), 32'd0);
        chk("async.cnt_sat", 32'(cnt_sat), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 16'h0020, 1'b0);
        step(1'b1, 16'h0020, 1'b0);
        chk("post_reset.res2", 32'(res), 32'd0);
        step(1'b1, 16'h0020, 1'b0);
        chk("post_reset.res3", 32'(res), 32'd1);
        chk("post_reset.cnt", 32'(rise_cnt), 32'd1);
        check_model("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
